// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the core's decoder.
// Holds the loader state encoding, the NOP fill word and the opcode map.
package loader_pkg;

  // Loader states: RUN serves the program, the L_* states form one load session.
  typedef enum logic [2:0] {
    RUN       = 3'd0,
    L_IDLE    = 3'd1,
    L_PRESS   = 3'd2,
    L_WRITE   = 3'd3,
    L_RELEASE = 3'd4
  } state_t;

  // Jump with immediate 0: the core simply advances to pc+1.
  localparam logic [7:0] NOP_WORD = 8'hC0;

  // Opcode field values, shared with the core's decoder.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Modulo-256 accumulate used by the optional session checksum.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button front end for the program loader.
// Synchronizes the raw strobe, debounces press and release, and walks the
// load-session states. Emits a single-cycle press_pulse per physical press.
// Dropping enable (synced load mode) returns to RUN at once and discards any
// press in flight, including one whose counter has already hit its limit.
module button_debounce
  import loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic strobe_raw,
  output logic press_pulse,
  output logic session_start,
  output logic active
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       strobe_sync;
  logic             strobe;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign strobe = strobe_sync[1];

  // Two-flop synchronizer for the asynchronous, bouncing button.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_sync <= 2'b00;
    end else begin
      strobe_sync <= {strobe_sync[0], strobe_raw};
    end
  end

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: press must be stable for DEBOUNCE_CYCLES samples, then
  // one write cycle, then release must be stable before another press counts.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!enable) begin
      state_next = RUN;
      cnt_next   = CNT_ZERO;
    end else begin
      case (state)
        RUN: begin
          state_next = L_IDLE;
          cnt_next   = CNT_ZERO;
        end
        L_IDLE: begin
          if (strobe) begin
            state_next = L_PRESS;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = L_IDLE;
          end
        end
        L_PRESS: begin
          if (!strobe) begin
            state_next = L_IDLE;
            cnt_next   = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_next = L_WRITE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        L_WRITE: begin
          state_next = L_RELEASE;
          cnt_next   = CNT_ZERO;
        end
        L_RELEASE: begin
          if (strobe) begin
            cnt_next = CNT_ZERO;
          end else if (cnt == CNT_LAST) begin
            state_next = L_IDLE;
            cnt_next   = CNT_ZERO;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = CNT_ZERO;
        end
      endcase
    end
  end

  assign press_pulse   = (state == L_WRITE) && enable;
  assign session_start = (state == RUN) && enable;
  assign active        = (state != RUN);

endmodule

// File: rtl/program_loader.sv
// Instruction store feeding the 8-bit core. In LOAD mode words keyed on the
// slide switches are committed one per debounced button press; in RUN mode
// the stored program is served with one oscillator cycle of latency.
// Optional build macro: LOADER_CHECKSUM_EN adds an 8-bit session checksum port.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              oscillator,
  input  logic              reset,
  input  logic              load_mode,
  input  logic [7:0]        load_data,
  input  logic              load_strobe,
  input  logic [7:0]        instruction_address,
  output logic [7:0]        instruction,
  output logic [ADDR_W:0]   load_count,
  output logic              loading,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              full
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [7:0]      ADDR_LIMIT = 8'(DEPTH);

  logic [1:0]        mode_sync;
  logic              press_pulse;
  logic              session_start;
  logic              write_en;
  logic              in_range;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        mem [DEPTH];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (oscillator),
    .reset        (reset),
    .enable       (mode_sync[1]),
    .strobe_raw   (load_strobe),
    .press_pulse  (press_pulse),
    .session_start(session_start),
    .active       (loading)
  );

  assign full     = (load_count == FULL_COUNT);
  assign write_en = press_pulse && !full;
  assign wr_ptr   = load_count[ADDR_W-1:0];
  assign in_range = (instruction_address < ADDR_LIMIT);
  assign rd_ptr   = instruction_address[ADDR_W-1:0];

  // Two-flop synchronizer for the load/run level switch.
  always_ff @(posedge oscillator) begin
    if (reset) begin
      mode_sync <= 2'b00;
    end else begin
      mode_sync <= {mode_sync[0], load_mode};
    end
  end

  // Program memory: NOP-filled on reset, one write per accepted press.
  always_ff @(posedge oscillator) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_WORD;
      end
    end else if (write_en) begin
      mem[wr_ptr] <= load_data;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Registered read port; LOAD states and out-of-range addresses give NOP.
  always_ff @(posedge oscillator) begin
    if (reset) begin
      instruction <= NOP_WORD;
    end else if (!loading && in_range) begin
      instruction <= mem[rd_ptr];
    end else begin
      instruction <= NOP_WORD;
    end
  end

  // Words written this session; cleared when a session opens, saturates at DEPTH.
  always_ff @(posedge oscillator) begin
    if (reset) begin
      load_count <= '0;
    end else if (session_start) begin
      load_count <= '0;
    end else if (write_en) begin
      load_count <= load_count + COUNT_ONE;
    end else begin
      load_count <= load_count;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running modulo-256 sum of the words written this session.
  always_ff @(posedge oscillator) begin
    if (reset) begin
      checksum <= 8'h00;
    end else if (session_start) begin
      checksum <= 8'h00;
    end else if (write_en) begin
      checksum <= sum8(checksum, load_data);
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule
